// File: rtl/move_scheduler.sv
// Move scheduler: queues cube move commands, issues them one at a time and redraws after each burst.
// Latency: command into an empty queue while idle -> move_start two edges later; redraw_req -> draw_start two edges later.
// Backpressure: cmd_ready drops while the queue is full; optional watchdog under `MOVE_SCHED_WATCHDOG_EN`.
module move_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int MOVE_W     = 4,
    parameter int WD_CYCLES  = 1048576
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            cmd_valid,
    input  logic [MOVE_W-1:0]               cmd_move,
    output logic                            cmd_ready,
    input  logic                            redraw_req,
    output logic                            move_start,
    output logic [MOVE_W-1:0]               move_code,
    input  logic                            move_done,
    output logic                            draw_start,
    input  logic                            draw_done,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] q_count,
    output logic                            err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WD_CYCLES < 1)
    begin : g_bad_cfg
        $error("move_scheduler: unsupported parameter value");
    end

    typedef enum logic [2:0] {
        INIT_DRAW, IDLE, MOVE_ISSUE, MOVE_WAIT, DRAW_ISSUE, DRAW_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               init_wait_q, init_wait_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [MOVE_W-1:0]  move_code_q, move_code_d;
    logic               move_start_q, move_start_d;
    logic               draw_start_q, draw_start_d;
    logic               pending_q, pending_d;
    logic [MOVE_W-1:0]  mem_q [FIFO_DEPTH];
    logic               push, pop, flush, wd_to;

    assign cmd_ready  = (count_q < DEPTH_C);
    assign push       = cmd_valid && cmd_ready;
    assign move_start = move_start_q;
    assign move_code  = move_code_q;
    assign draw_start = draw_start_q;
    assign busy       = (state_q != IDLE);
    assign q_count    = count_q;

`ifdef MOVE_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
    logic            in_wait;

    assign in_wait = (state_q == MOVE_WAIT) || (state_q == DRAW_WAIT) ||
                     ((state_q == INIT_DRAW) && init_wait_q);
    // Fires on the WD_CYCLES-th consecutive cycle spent in one wait state.
    assign wd_to = in_wait && (wd_cnt_q == WD_LIM);
    assign err   = err_q;

    always_comb begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (!in_wait || state_d != state_q) begin
            wd_cnt_d = '0;
        end
        err_d = err_q | wd_to;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    assign wd_to = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        init_wait_d = init_wait_q;
        pop         = 1'b0;
        flush       = 1'b0;
        case (state_q)
            INIT_DRAW: begin
                if (!init_wait_q) begin
                    init_wait_d = 1'b1;
                end else if (draw_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // A queued move wins over a pending redraw; the post-move draw covers it.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = MOVE_ISSUE;
                end else if (pending_q) begin
                    state_d = DRAW_ISSUE;
                end
            end
            MOVE_ISSUE: state_d = MOVE_WAIT;
            MOVE_WAIT: begin
                if (move_done) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = MOVE_ISSUE;
                    end else begin
                        state_d = DRAW_ISSUE;
                    end
                end
            end
            DRAW_ISSUE: state_d = DRAW_WAIT;
            DRAW_WAIT: begin
                if (draw_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wd_to) begin
            state_d = IDLE;
            pop     = 1'b0;
            flush   = 1'b1;
        end

        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        move_code_d = pop ? mem_q[rd_ptr_q] : move_code_q;
        // Pending clears on entry to DRAW_ISSUE, but a request on that same edge survives.
        pending_d   = redraw_req || (pending_q && (state_d != DRAW_ISSUE));
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pending_d = 1'b0;
        end

        move_start_d = (state_d == MOVE_ISSUE);
        draw_start_d = (state_d == DRAW_ISSUE) || ((state_q == INIT_DRAW) && !init_wait_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_move;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= INIT_DRAW;
            init_wait_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            move_code_q  <= '0;
            move_start_q <= 1'b0;
            draw_start_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_wait_q  <= init_wait_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            move_code_q  <= move_code_d;
            move_start_q <= move_start_d;
            draw_start_q <= draw_start_d;
            pending_q    <= pending_d;
        end
    end
endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue entries, power of two, 2..16.
REQ-002 Parameter MOVE_W, default 4: move code width; codes 0-11 are the face turns, 12-15 are reserved and passed through unchanged.
REQ-003 Parameter WD_CYCLES, default 1048576: watchdog limit in clocks, used only when MOVE_SCHED_WATCHDOG_EN is defined.
REQ-004 Ports SHALL be:
- CLOCK_50  in  1: sole clock; all logic on the rising edge.
- reset  in  1: asynchronous, active-high.
- cmd_valid  in  1: move command offered.
- cmd_move  in  MOVE_W: move code.
- cmd_ready  out  1: queue can accept.
- redraw_req  in  1: one-cycle pulse requesting a frame redraw with no move.
- move_start  out  1: one-cycle pulse to the cube logic.
- move_code  out  MOVE_W: move being applied, held stable until move_done.
- move_done  in  1: cube logic finished the move.
- draw_start  out  1: one-cycle pulse to cube_drawer.
- draw_done  in  1: cube_drawer finished the full-frame pass.
- busy  out  1: high in any state other than IDLE.
- q_count  out  clog2(FIFO_DEPTH+1): queue occupancy.
- err  out  1: sticky watchdog error.

Function
REQ-005 Command accepted on an edge where cmd_valid and cmd_ready are both high; cmd_ready = (q_count < FIFO_DEPTH), registered-count based, no combinational path from cmd_valid.
REQ-006 Queue is FIFO with wrap-around pointers; push while full is impossible by REQ-005; a push and pop on the same edge leave q_count unchanged.
REQ-007 FSM states: INIT_DRAW, IDLE, MOVE_ISSUE, MOVE_WAIT, DRAW_ISSUE, DRAW_WAIT.
REQ-008 IDLE with q_count>0: pop head into move_code and go to MOVE_ISSUE; move_start is high for exactly the MOVE_ISSUE cycle; next state MOVE_WAIT.
REQ-009 Latency: a command accepted at edge N into an empty queue while in IDLE produces move_start high in the cycle following edge N+1.
REQ-010 MOVE_WAIT on move_done: if q_count>0, pop and go to MOVE_ISSUE (moves coalesce, no intermediate draw); otherwise go to DRAW_ISSUE.
REQ-011 DRAW_ISSUE: draw_start is high for exactly one cycle; next state DRAW_WAIT; DRAW_WAIT returns to IDLE on draw_done.
REQ-012 redraw_req sets a pending flag in any state; IDLE with q_count==0 and the flag set goes to DRAW_ISSUE; the flag clears on entry to DRAW_ISSUE (any cause); a redraw_req arriving on that same edge stays pending.
REQ-013 In IDLE, a queued move has priority over a pending redraw; the redraw is satisfied by the post-move draw.
REQ-014 move_done is ignored outside MOVE_WAIT; draw_done is ignored outside DRAW_WAIT and INIT_DRAW's wait phase.
REQ-015 Commands are accepted in every state, including while busy.

Reset
REQ-016 On reset assertion, asynchronously: queue empty, pointers 0, q_count=0, move_code=0, move_start=0, draw_start=0, pending flag=0, err=0, state=INIT_DRAW.
REQ-017 INIT_DRAW issues one draw_start pulse on the first clock after reset release, then waits for draw_done and goes to IDLE, painting the solved cube; busy is high throughout.
REQ-018 Reset mid-operation discards queued and in-flight commands; no further move_start is issued until after the initial draw completes.

Configuration
REQ-019 With MOVE_SCHED_WATCHDOG_EN defined: a counter runs in MOVE_WAIT, DRAW_WAIT and INIT_DRAW's wait phase and clears on state change; when it reaches WD_CYCLES, set err (sticky until reset), discard the queue and the pending flag, and go to IDLE.
REQ-020 Without MOVE_SCHED_WATCHDOG_EN: no counter exists, the wait states wait indefinitely, and err is tied to 0.

Verification
REQ-021 Release reset, assert draw_done 10 cycles after draw_start -> exactly 1 draw_start, no move_start, busy falls, state IDLE.
REQ-022 In IDLE, push move 5 at edge N -> move_start in the cycle after edge N+1 with move_code=5; move_done -> 1 draw_start; draw_done -> IDLE.
REQ-023 Push 3, 7, 9 back-to-back, then answer each move_done after 4 cycles -> move_code sequence 3,7,9 and a single draw_start after move 9.
REQ-024 FIFO_DEPTH=4, hold move_done low, offer 6 commands -> 1 issued, 4 queued, cmd_ready=0, q_count=4, and the 6th is not accepted until a pop.
REQ-025 redraw_req during MOVE_WAIT with an empty queue -> one draw only after move_done; redraw_req in IDLE -> draw_start 2 cycles later.
REQ-026 With MOVE_SCHED_WATCHDOG_EN and WD_CYCLES=16, withhold move_done -> err=1 at cycle 16 of MOVE_WAIT, q_count=0, IDLE; err holds until reset.
